// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: routes one valid/ready stream to four channels selected per beat by in_sel.
// Latency: 1 cycle. A beat pushed at edge N appears on its channel head from edge N onward.
// Backpressure: in_ready drops only when the selected channel FIFO is full. A stalled consumer blocks only its own channel.
//
// Ports:
//   clk, rst             single clock, asynchronous active-high reset
//   in_data/in_sel       input beat and its destination channel (0..3)
//   in_valid/in_ready    input handshake; in_ready = !full[in_sel]
//   data_out_0..3        channel FIFO heads, forced to zero while the channel is empty
//   out_valid/out_ready  per-channel output handshake, bit k = channel k
//   xfer_cnt             per-channel push counters, channel k at [k*CNT_W +: CNT_W]
//                        (present only when the DEMUX_COUNT_EN macro is defined)
// Parameters: WIDTH (data width), DEPTH (entries per channel, power of two >= 2),
//             CNT_W (counter width, used only with DEMUX_COUNT_EN)

module demux_1to4_stream #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   data_out_0,
   output logic [WIDTH-1:0]   data_out_1,
   output logic [WIDTH-1:0]   data_out_2,
   output logic [WIDTH-1:0]   data_out_3,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready
`ifdef DEMUX_COUNT_EN
   ,
   output logic [4*CNT_W-1:0] xfer_cnt
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = PTR_W + 1;

   // Channel storage. It is not reset because heads are masked to zero while empty.
   logic [WIDTH-1:0] mem_q [4][DEPTH];

   logic [PTR_W-1:0] wr_ptr_q [4];
   logic [PTR_W-1:0] wr_ptr_d [4];
   logic [PTR_W-1:0] rd_ptr_q [4];
   logic [PTR_W-1:0] rd_ptr_d [4];
   logic [OCC_W-1:0] occ_q    [4];
   logic [OCC_W-1:0] occ_d    [4];

   logic [3:0]       full;
   logic [3:0]       push;
   logic [3:0]       pop;
   logic [WIDTH-1:0] head     [4];

   // Handshake decode. Fullness comes from the registered occupancy only, so a
   // pop in the same cycle never frees room for the incoming beat.
   always_comb begin
      full      = '0;
      out_valid = '0;
      push      = '0;
      pop       = '0;
      for (int k = 0; k < 4; k++) begin
         full[k]      = (occ_q[k] == OCC_W'(DEPTH));
         out_valid[k] = (occ_q[k] != '0);
      end
      in_ready = !full[in_sel];
      for (int k = 0; k < 4; k++) begin
         push[k] = in_valid && in_ready && (in_sel == 2'(k));
         pop[k]  = out_valid[k] && out_ready[k];
      end
   end

   // Next-state pointers and occupancy. Pointers wrap naturally because DEPTH
   // is a power of two.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         wr_ptr_d[k] = wr_ptr_q[k];
         rd_ptr_d[k] = rd_ptr_q[k];
         occ_d[k]    = occ_q[k];
         if (push[k]) begin
            wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
         end
         if (pop[k]) begin
            rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
         end
         // A simultaneous push and pop leaves the occupancy unchanged.
         case ({push[k], pop[k]})
            2'b10:   occ_d[k] = occ_q[k] + OCC_W'(1);
            2'b01:   occ_d[k] = occ_q[k] - OCC_W'(1);
            default: occ_d[k] = occ_q[k];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            occ_q[k]    <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            wr_ptr_q[k] <= wr_ptr_d[k];
            rd_ptr_q[k] <= rd_ptr_d[k];
            occ_q[k]    <= occ_d[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (push[k]) begin
            mem_q[k][wr_ptr_q[k]] <= in_data;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         head[k] = out_valid[k] ? mem_q[k][rd_ptr_q[k]] : '0;
      end
   end

   assign data_out_0 = head[0];
   assign data_out_1 = head[1];
   assign data_out_2 = head[2];
   assign data_out_3 = head[3];

`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0] xfer_q [4];

   // Counters wrap from all-ones back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            xfer_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
               xfer_q[k] <= xfer_q[k] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      xfer_cnt = '0;
      for (int k = 0; k < 4; k++) begin
         xfer_cnt[k*CNT_W +: CNT_W] = xfer_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed and scoreboard checks for demux_1to4_stream with WIDTH=4, DEPTH=2, and CNT_W=8.
module tb_demux_1to4_stream;

   localparam int WIDTH = 4;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_out_0, data_out_1, data_out_2, data_out_3;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
`ifdef DEMUX_COUNT_EN
   logic [4*CNT_W-1:0] xfer_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] dout [4];
   assign dout[0] = data_out_0;
   assign dout[1] = data_out_1;
   assign dout[2] = data_out_2;
   assign dout[3] = data_out_3;

   demux_1to4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_out_0 (data_out_0),
      .data_out_1 (data_out_1),
      .data_out_2 (data_out_2),
      .data_out_3 (data_out_3),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
`ifdef DEMUX_COUNT_EN
      ,
      .xfer_cnt   (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
      #12;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
      n_checks++;
      if ({data_out_0, data_out_1, data_out_2, data_out_3} !== 16'h0000) begin
         n_fail++; $display("FAIL reset_data: got %h want 0000", {data_out_0, data_out_1, data_out_2, data_out_3});
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_beat();
      in_sel = 2'd2; in_data = 4'hA; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL single_valid: got %b want 0100", out_valid); end
      n_checks++;
      if (data_out_2 !== 4'hA) begin n_fail++; $display("FAIL single_data2: got %h want a", data_out_2); end
      n_checks++;
      if ({data_out_0, data_out_1, data_out_3} !== 12'h000) begin
         n_fail++; $display("FAIL single_others: got %h want 000", {data_out_0, data_out_1, data_out_3});
      end
      out_ready = 4'b0100;
      step();
      out_ready = 4'b0000;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_drain: got %b want 0000", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 4'b0000;
      in_sel = 2'd0; in_valid = 1'b1;
      in_data = 4'h1; step();
      in_data = 4'h2; step();
      in_data = 4'h3; #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
      out_ready = 4'b0001; #1;
      // Even with a pop pending on channel 0, a full channel must not accept the beat.
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_pushthrough: got %b want 0", in_ready); end
      out_ready = 4'b0000;
      step();
      n_checks++;
      if (data_out_0 !== 4'h1) begin n_fail++; $display("FAIL bp_head_hold: got %h want 1", data_out_0); end
      in_sel = 2'd1; in_data = 4'h7; #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0011 || data_out_1 !== 4'h7) begin
         n_fail++; $display("FAIL bp_ch1: got valid=%b d1=%h want 0011/7", out_valid, data_out_1);
      end
      out_ready = 4'b0001;
      step();
      n_checks++;
      if (data_out_0 !== 4'h2) begin n_fail++; $display("FAIL bp_order: got %h want 2", data_out_0); end
      step();
      n_checks++;
      if (out_valid[0] !== 1'b0 || data_out_0 !== 4'h0) begin
         n_fail++; $display("FAIL bp_empty0: got v=%b d=%h want 0/0", out_valid[0], data_out_0);
      end
      out_ready = 4'b0010;
      step();
      out_ready = 4'b0000;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drain: got %b want 0000", out_valid); end
   endtask

   task automatic test_push_pop_same();
      in_sel = 2'd3; in_data = 4'h5; in_valid = 1'b1;
      step();
      in_data = 4'h6; out_ready = 4'b1000;
      step();
      in_valid = 1'b0; out_ready = 4'b0000;
      n_checks++;
      if (out_valid !== 4'b1000 || data_out_3 !== 4'h6) begin
         n_fail++; $display("FAIL pp_head: got v=%b d3=%h want 1000/6", out_valid, data_out_3);
      end
      in_sel = 2'd3; #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_occ_not_full: got %b want 1", in_ready); end
      out_ready = 4'b1000;
      step();
      out_ready = 4'b0000;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL pp_occ_one: got %b want 0000", out_valid); end
   endtask

   task automatic test_reset_mid();
      in_sel = 2'd1; in_valid = 1'b1;
      in_data = 4'h8; step();
      in_data = 4'h9; step();
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_full: got %b want 0", in_ready); end
      rst = 1'b1; #2;
      n_checks++;
      if (out_valid !== 4'b0000 || data_out_1 !== 4'h0) begin
         n_fail++; $display("FAIL rm_async: got v=%b d1=%h want 0000/0", out_valid, data_out_1);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_in_rst: got %b want 1", in_ready); end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      step();
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s); #1;
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_sel%0d: got %b want 1", s, in_ready); end
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] q [4][$];
      logic exp_rdy;
      int   prints = 0;
      for (int c = 0; c < 3000 + 4; c++) begin
         if (c < 3000) begin
            in_valid  = 1'($urandom);
            in_sel    = 2'($urandom);
            in_data   = 4'($urandom);
            out_ready = 4'($urandom);
         end else begin
            in_valid  = 1'b0;
            out_ready = 4'b1111;
         end
         #1;
         exp_rdy = (q[in_sel].size() < DEPTH);
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++;
            if (prints++ < 10) $display("FAIL rnd_ready c=%0d: got %b want %b", c, in_ready, exp_rdy);
         end
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid[k] !== (q[k].size() != 0)) begin
               n_fail++;
               if (prints++ < 10) $display("FAIL rnd_valid%0d c=%0d: got %b want %b", k, c, out_valid[k], q[k].size() != 0);
            end else if (q[k].size() != 0) begin
               n_checks++;
               if (dout[k] !== q[k][0]) begin
                  n_fail++;
                  if (prints++ < 10) $display("FAIL rnd_data%0d c=%0d: got %h want %h", k, c, dout[k], q[k][0]);
               end
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
         end
         if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
         step();
      end
      in_valid = 1'b0; out_ready = 4'b0000;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rnd_final: got %b want 0000", out_valid); end
   endtask

`ifdef DEMUX_COUNT_EN
   task automatic test_count();
      rst = 1'b1; #2;
      @(negedge clk);
      rst = 1'b0;
      in_sel = 2'd0; in_valid = 1'b1; out_ready = 4'b0001;
      for (int i = 0; i < 257; i++) begin
         in_data = 4'(i);
         step();
      end
      in_valid = 1'b0;
      n_checks++;
      if (xfer_cnt[7:0] !== 8'd1) begin n_fail++; $display("FAIL cnt_wrap: got %0d want 1", xfer_cnt[7:0]); end
      n_checks++;
      if (xfer_cnt[31:8] !== 24'd0) begin n_fail++; $display("FAIL cnt_others: got %h want 000000", xfer_cnt[31:8]); end
      step();
      out_ready = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_single_beat();
      test_backpressure();
      test_push_pop_same();
      test_reset_mid();
      test_random();
`ifdef DEMUX_COUNT_EN
      test_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
